// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    // Register stages between accept and out_valid.
    localparam int unsigned LAT = 4;

    // Ceiling log2, for sizing counters or indices derived from WIDTH.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

    // Operand widths the recursion supports: 8, 16, 32 or 64.
    function automatic bit width_is_legal(input int unsigned w);
        return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_mul_core.sv
// Combinational Urdhva-Tiryagbhyam multiplier. Splits each operand into halves and
// recurses until the operands are 8 bits or narrower, where a plain leaf multiply is used.
module vedic_mul_core
    import vedic_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);

    localparam int unsigned PW = 2 * W;

    if (W <= 8) begin : g_leaf
        assign o_p = PW'(i_a) * PW'(i_b);
    end else begin : g_split
        localparam int unsigned H  = W / 2;
        localparam int unsigned MW = W + 1;

        logic [W-1:0]  w_ll;
        logic [W-1:0]  w_lh;
        logic [W-1:0]  w_hl;
        logic [W-1:0]  w_hh;
        logic [MW-1:0] w_mid;

        vedic_mul_core #(.W(H)) u_ll (
            .i_a (i_a[H-1:0]),
            .i_b (i_b[H-1:0]),
            .o_p (w_ll)
        );
        vedic_mul_core #(.W(H)) u_lh (
            .i_a (i_a[H-1:0]),
            .i_b (i_b[W-1:H]),
            .o_p (w_lh)
        );
        vedic_mul_core #(.W(H)) u_hl (
            .i_a (i_a[W-1:H]),
            .i_b (i_b[H-1:0]),
            .o_p (w_hl)
        );
        vedic_mul_core #(.W(H)) u_hh (
            .i_a (i_a[W-1:H]),
            .i_b (i_b[W-1:H]),
            .o_p (w_hh)
        );

        // Cross terms keep their carry so the recombination cannot lose a bit.
        assign w_mid = MW'(w_lh) + MW'(w_hl);
        assign o_p   = (PW'(w_hh) << W) + (PW'(w_mid) << H) + PW'(w_ll);
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Four-stage pipelined Vedic multiplier with valid/ready on both sides, signed or
// unsigned per transaction, and a user tag carried alongside each product.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned MW   = WIDTH + 1;

    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be 8, 16, 32 or 64");
    end

    // Global stall: every stage moves together, bubbles included.
    logic w_en;

    logic r1_valid;
    logic r2_valid;
    logic r3_valid;
    logic r4_valid;

    // S1: magnitudes and sign of the result
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg;
    logic [WIDTH-1:0] r1_mag_a;
    logic [WIDTH-1:0] r1_mag_b;
    logic             r1_neg;
    logic [TAG_W-1:0] r1_tag;

    // S2: half-width partial products
    logic [WIDTH-1:0] w_ll;
    logic [WIDTH-1:0] w_lh;
    logic [WIDTH-1:0] w_hl;
    logic [WIDTH-1:0] w_hh;
    logic [WIDTH-1:0] r2_ll;
    logic [WIDTH-1:0] r2_lh;
    logic [WIDTH-1:0] r2_hl;
    logic [WIDTH-1:0] r2_hh;
    logic             r2_neg;
    logic [TAG_W-1:0] r2_tag;

    // S3: cross-term sum
    logic [MW-1:0]    w_mid;
    logic [WIDTH-1:0] r3_ll;
    logic [WIDTH-1:0] r3_hh;
    logic [MW-1:0]    r3_mid;
    logic             r3_neg;
    logic [TAG_W-1:0] r3_tag;

    // S4: final recombination and sign fix-up
    logic [PW-1:0]    w_p;
    logic [PW-1:0]    w_p_fixed;
    logic [PW-1:0]    r4_p;
    logic [TAG_W-1:0] r4_tag;

    assign w_en      = !r4_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r4_valid;
    assign out_p     = r4_p;
    assign out_tag   = r4_tag;
    assign busy      = r1_valid || r2_valid || r3_valid || r4_valid;

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
    // correct unsigned magnitude.
    assign w_mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign w_mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign w_neg   = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

    vedic_mul_core #(.W(HALF)) u_core_ll (
        .i_a (r1_mag_a[HALF-1:0]),
        .i_b (r1_mag_b[HALF-1:0]),
        .o_p (w_ll)
    );
    vedic_mul_core #(.W(HALF)) u_core_lh (
        .i_a (r1_mag_a[HALF-1:0]),
        .i_b (r1_mag_b[WIDTH-1:HALF]),
        .o_p (w_lh)
    );
    vedic_mul_core #(.W(HALF)) u_core_hl (
        .i_a (r1_mag_a[WIDTH-1:HALF]),
        .i_b (r1_mag_b[HALF-1:0]),
        .o_p (w_hl)
    );
    vedic_mul_core #(.W(HALF)) u_core_hh (
        .i_a (r1_mag_a[WIDTH-1:HALF]),
        .i_b (r1_mag_b[WIDTH-1:HALF]),
        .o_p (w_hh)
    );

    assign w_mid     = MW'(r2_lh) + MW'(r2_hl);
    assign w_p       = (PW'(r3_hh) << WIDTH) + (PW'(r3_mid) << HALF) + PW'(r3_ll);
    assign w_p_fixed = r3_neg ? -w_p : w_p;

    // Stage valid bits: reset clears all in-flight entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
            r4_valid <= 1'b0;
        end else if (w_en) begin
            r1_valid <= in_valid;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
            r4_valid <= r3_valid;
        end
    end

    // Internal stage data: qualified by the valid bits, so left unreset.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_mag_a <= w_mag_a;
            r1_mag_b <= w_mag_b;
            r1_neg   <= w_neg;
            r1_tag   <= in_tag;
            r2_ll    <= w_ll;
            r2_lh    <= w_lh;
            r2_hl    <= w_hl;
            r2_hh    <= w_hh;
            r2_neg   <= r1_neg;
            r2_tag   <= r1_tag;
            r3_ll    <= r2_ll;
            r3_hh    <= r2_hh;
            r3_mid   <= w_mid;
            r3_neg   <= r2_neg;
            r3_tag   <= r2_tag;
        end
    end

    // Output data: only real products overwrite it, so it holds through stalls and bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r4_p   <= '0;
            r4_tag <= '0;
        end else if (w_en && r3_valid) begin
            r4_p   <= w_p_fixed;
            r4_tag <= r3_tag;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench: directed checks on a 16-bit instance, then concurrent random
// regressions at WIDTH 8, 16, 32 and 64 against an arithmetic reference model.
module tb_vedic_mult_pipe;

    localparam int unsigned TW           = 8;
    localparam int          N_RAND       = 10000;
    localparam int          RAND_CYC_MAX = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_fails;
    logic rnd_go;
    logic rnd_rst_n;
    int   rnd_finished;

    // Directed-test instance
    logic          d_rst_n;
    logic          d_in_valid;
    logic          d_in_ready;
    logic [15:0]   d_in_a;
    logic [15:0]   d_in_b;
    logic          d_in_signed;
    logic [TW-1:0] d_in_tag;
    logic          d_out_valid;
    logic          d_out_ready;
    logic [31:0]   d_out_p;
    logic [TW-1:0] d_out_tag;
    logic          d_busy;

    vedic_mult_pipe #(.WIDTH(16), .TAG_W(TW)) u_dut (
        .clk       (clk),
        .rst_n     (d_rst_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_a      (d_in_a),
        .in_b      (d_in_b),
        .in_signed (d_in_signed),
        .in_tag    (d_in_tag),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_p     (d_out_p),
        .out_tag   (d_out_tag),
        .busy      (d_busy)
    );

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference product: interpret operands as w-bit integers, multiply, keep 2w bits.
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input int w);
        logic signed [127:0] xa;
        logic signed [127:0] xb;
        logic signed [127:0] pr;
        logic [127:0]        mask;
        xa = {64'd0, a};
        xb = {64'd0, b};
        if (s && a[w-1]) xa = xa - (128'sd1 <<< w);
        if (s && b[w-1]) xb = xb - (128'sd1 <<< w);
        pr   = xa * xb;
        mask = (128'd1 << (2 * w)) - 128'd1;
        return pr & mask;
    endfunction

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [31:0] exp);
        int waited;
        waited = 0;
        @(negedge clk);
        d_in_a      = a;
        d_in_b      = b;
        d_in_signed = s;
        d_in_tag    = 8'hA5;
        d_in_valid  = 1'b1;
        d_out_ready = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        while (!d_out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_eq("single_valid", d_out_valid, 1);
        check_eq("single_lat", waited, 3);
        check_eq("single_p", d_out_p, exp);
        check_eq("single_tag", d_out_tag, 8'hA5);
    endtask

    // Stream n random pairs; out_ready is dropped for stall_len cycles from stall_at.
    task automatic stream_test(input int n, input int stall_at, input int stall_len);
        logic [127:0]  exp_q[$];
        logic [TW-1:0] tag_q[$];
        int            sent;
        int            got;
        int            cyc;
        int            last_out;
        logic          hold;
        logic [31:0]   hold_p;
        logic [TW-1:0] hold_tag;
        logic [15:0]   a;
        logic [15:0]   b;
        logic          s;
        sent = 0; got = 0; cyc = 0; last_out = 0;
        hold = 1'b0; hold_p = '0; hold_tag = '0;
        a = 16'($urandom); b = 16'($urandom); s = 1'($urandom_range(0, 1));
        while (got < n && cyc < n + stall_len + 20) begin
            @(negedge clk);
            d_out_ready = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
            d_in_valid  = (sent < n);
            d_in_a      = a;
            d_in_b      = b;
            d_in_signed = s;
            d_in_tag    = TW'(sent);
            #1;
            if (hold) begin
                check_eq("hold_valid", d_out_valid, 1);
                check_eq("hold_p", d_out_p, hold_p);
                check_eq("hold_tag", d_out_tag, hold_tag);
            end
            if (!d_out_ready) check_eq("stall_in_ready", d_in_ready, 0);
            if (d_in_valid && d_in_ready) begin
                exp_q.push_back(ref_mul(64'(a), 64'(b), s, 16));
                tag_q.push_back(d_in_tag);
                sent++;
                a = 16'($urandom); b = 16'($urandom); s = 1'($urandom_range(0, 1));
            end
            if (d_out_valid && d_out_ready) begin
                if (got == 0) check_eq("stream_first", cyc, 4);
                if (stall_len == 0 && got > 0) check_eq("stream_gap", cyc, last_out + 1);
                check_eq("stream_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("stream_p", d_out_p, exp_q.pop_front());
                    check_eq("stream_tag", d_out_tag, tag_q.pop_front());
                end
                got++;
                last_out = cyc;
            end
            hold     = d_out_valid && !d_out_ready;
            hold_p   = d_out_p;
            hold_tag = d_out_tag;
            cyc++;
        end
        check_eq("stream_count", got, n);
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("stream_no_dup", d_out_valid, 0);
        end
    endtask

    // Random regression at each legal width, all running in parallel on one clock.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        localparam int W = 8 << gi;

        logic           in_valid;
        logic           in_ready;
        logic [W-1:0]   in_a;
        logic [W-1:0]   in_b;
        logic           in_signed;
        logic [TW-1:0]  in_tag;
        logic           out_valid;
        logic           out_ready;
        logic [2*W-1:0] out_p;
        logic [TW-1:0]  out_tag;
        logic           busy;

        vedic_mult_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
            .clk       (clk),
            .rst_n     (rnd_rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_signed (in_signed),
            .in_tag    (in_tag),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_p     (out_p),
            .out_tag   (out_tag),
            .busy      (busy)
        );

        initial begin
            logic [127:0]   exp_q[$];
            logic [TW-1:0]  tag_q[$];
            int             sent;
            int             cyc;
            int             k;
            logic           hold;
            logic [2*W-1:0] hold_p;
            logic [TW-1:0]  hold_tag;
            logic [63:0]    ra;
            logic [63:0]    rb;
            logic [63:0]    v_min;
            logic [63:0]    v_ones;
            in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0;
            in_a = '0; in_b = '0; in_tag = '0;
            sent = 0; cyc = 0; hold = 1'b0; hold_p = '0; hold_tag = '0;
            v_min  = 64'd1 << (W - 1);
            v_ones = (64'd1 << W) - 64'd1;
            wait (rnd_go);
            while ((sent < N_RAND || exp_q.size() != 0) && cyc < RAND_CYC_MAX) begin
                @(negedge clk);
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                k  = int'($urandom_range(0, 15));
                if (k == 0) ra = v_min;
                if (k == 1) ra = v_ones;
                if (k == 2) rb = v_min;
                if (k == 3) rb = v_ones;
                if (k == 4) ra = 64'd0;
                if (k == 5) begin ra = v_min; rb = v_min; end
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 4) != 0) && (sent < N_RAND);
                in_signed = 1'($urandom_range(0, 1));
                in_a      = W'(ra);
                in_b      = W'(rb);
                in_tag    = TW'(sent);
                #1;
                if (hold) begin
                    check_eq("rand_hold_valid", out_valid, 1);
                    check_eq("rand_hold_p", out_p, hold_p);
                    check_eq("rand_hold_tag", out_tag, hold_tag);
                end
                check_eq("rand_in_ready", in_ready, !out_valid || out_ready);
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_mul(64'(in_a), 64'(in_b), in_signed, W));
                    tag_q.push_back(in_tag);
                    sent++;
                end
                if (out_valid && out_ready) begin
                    check_eq("rand_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check_eq("rand_p", out_p, exp_q.pop_front());
                        check_eq("rand_tag", out_tag, tag_q.pop_front());
                    end
                end
                hold     = out_valid && !out_ready;
                hold_p   = out_p;
                hold_tag = out_tag;
                cyc++;
            end
            check_eq("rand_complete", (sent == N_RAND) && (exp_q.size() == 0), 1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            rnd_finished++;
        end
    end

    initial begin
        int guard;
        n_checks = 0; n_fails = 0;
        rnd_go = 1'b0; rnd_rst_n = 1'b0; rnd_finished = 0;
        d_rst_n = 1'b0; d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0;
        d_in_signed = 1'b0; d_in_tag = '0; d_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_out_valid", d_out_valid, 0);
        check_eq("rst_busy", d_busy, 0);
        check_eq("rst_in_ready", d_in_ready, 1);
        check_eq("rst_out_p", d_out_p, 0);
        check_eq("rst_out_tag", d_out_tag, 0);
        d_rst_n   = 1'b1;
        rnd_rst_n = 1'b1;
        @(negedge clk);

        // First product and its latency
        d_in_a = 16'h1234; d_in_b = 16'h5678; d_in_signed = 1'b0;
        d_in_tag = 8'h3C; d_in_valid = 1'b1; d_out_ready = 1'b1;
        #1 check_eq("t1_in_ready", d_in_ready, 1);
        @(negedge clk);
        d_in_valid = 1'b0;
        check_eq("t1_lat1", d_out_valid, 0);
        check_eq("t1_busy", d_busy, 1);
        @(negedge clk);
        check_eq("t1_lat2", d_out_valid, 0);
        @(negedge clk);
        check_eq("t1_lat3", d_out_valid, 0);
        @(negedge clk);
        check_eq("t1_lat4", d_out_valid, 1);
        check_eq("t1_p", d_out_p, 32'h0626_0060);
        check_eq("t1_tag", d_out_tag, 8'h3C);
        @(negedge clk);
        check_eq("t1_drained", d_out_valid, 0);
        check_eq("t1_idle", d_busy, 0);

        // Signed corner products
        run_one(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
        run_one(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        run_one(16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000);
        run_one(16'h7FFF, 16'hFFFF, 1'b1, 32'hFFFF_8001);
        run_one(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);

        // Full-throughput streaming, then a 6-cycle back-pressure window
        stream_test(20, 0, 0);
        stream_test(12, 5, 6);

        // Reset with three entries in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_in_a = 16'($urandom); d_in_b = 16'($urandom);
            d_in_signed = 1'b0; d_in_tag = TW'(i); d_in_valid = 1'b1;
        end
        @(negedge clk);
        d_in_valid = 1'b0;
        check_eq("mid_busy", d_busy, 1);
        d_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", d_out_valid, 0);
        check_eq("mid_rst_busy", d_busy, 0);
        @(negedge clk);
        d_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("mid_rst_stale", d_out_valid, 0);
        end

        // Random regressions
        rnd_go = 1'b1;
        guard  = 0;
        while (rnd_finished < 4 && guard < RAND_CYC_MAX + 1000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("rand_all_done", rnd_finished, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
